// File: rtl/song_play_ctrl.sv
// Purpose : steps the note ROM through the selected song, times each note and mutes between notes.
// Latency : a button pulse takes effect on the next clock edge; each note takes 2 + note_len*BEAT_TICKS cycles.
// Backpr. : none; stop > song change > play/pause > normal sequencing when they coincide.
module song_play_ctrl #(
  parameter int BEAT_TICKS = 25_000_000,
  parameter int GAP_TICKS  = 1_000_000,
  parameter int NOTE_AW    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         song_sel,
  input  logic               play_btn,
  input  logic               stop_btn,
  input  logic [3:0]         note_len,
  output logic [2:0]         rom_song,
  output logic [NOTE_AW-1:0] note_addr,
  output logic               playing,
  output logic               mute,
  output logic               song_done
);

  localparam int TW = (BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(BEAT_TICKS - 1);
  localparam logic [TW-1:0] T_GAP  = TW'(BEAT_TICKS - GAP_TICKS - 1);

  typedef enum logic [2:0] {IDLE, FETCH, PLAY, GAP, PAUSE} state_t;

  state_t          state;
  state_t          ret_state;
  logic            fetch_cnt;
  logic [TW-1:0]   tick_cnt;
  logic [3:0]      beats_left;

  logic song_ok;
  logic song_chg;
  logic tick_end;
  logic gap_hit;
  logic last_addr;

  // Decode of the conditions shared by several transitions.
  assign song_ok   = (song_sel <= 3'd5);
  assign song_chg  = (state != IDLE) && song_ok && (song_sel != rom_song);
  assign tick_end  = (tick_cnt == T_LAST);
  assign gap_hit   = (beats_left == 4'd1) && (tick_cnt == T_GAP);
  assign last_addr = (note_addr == {NOTE_AW{1'b1}});

  // Sequencer: state, counters and registered outputs move together.
  // The tick counter keeps running through GAP, so the gap ends at the same
  // wrap point that would have ended the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ret_state  <= PLAY;
      fetch_cnt  <= 1'b0;
      tick_cnt   <= '0;
      beats_left <= '0;
      rom_song   <= '0;
      note_addr  <= '0;
      playing    <= 1'b0;
      mute       <= 1'b1;
      song_done  <= 1'b0;
    end else begin
      song_done <= 1'b0;
      if (state != IDLE && stop_btn) begin
        state     <= IDLE;
        note_addr <= '0;
        playing   <= 1'b0;
        mute      <= 1'b1;
      end else if (song_chg) begin
        rom_song  <= song_sel;
        note_addr <= '0;
        fetch_cnt <= 1'b0;
        state     <= FETCH;
        playing   <= 1'b1;
        mute      <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (play_btn) begin
              if (song_ok) rom_song <= song_sel;
              note_addr <= '0;
              fetch_cnt <= 1'b0;
              state     <= FETCH;
              playing   <= 1'b1;
              mute      <= 1'b1;
            end
          end
          FETCH: begin
            // First cycle presents the address; the ROM answers in the second.
            if (!fetch_cnt) begin
              fetch_cnt <= 1'b1;
            end else if (note_len == 4'd0) begin
              song_done <= 1'b1;
              note_addr <= '0;
              state     <= IDLE;
              playing   <= 1'b0;
            end else begin
              beats_left <= note_len;
              tick_cnt   <= '0;
              state      <= PLAY;
              mute       <= 1'b0;
            end
          end
          PLAY: begin
            // The cycle in which pause is pressed still counts as played time.
            if (tick_end && !gap_hit) begin
              tick_cnt   <= '0;
              beats_left <= beats_left - 4'd1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
            if (play_btn) begin
              state     <= PAUSE;
              ret_state <= gap_hit ? GAP : PLAY;
              mute      <= 1'b1;
            end else if (gap_hit) begin
              state <= GAP;
              mute  <= 1'b1;
            end
          end
          GAP: begin
            if (tick_end) begin
              if (last_addr) begin
                // No wrap: the address stays at the last note.
                song_done <= 1'b1;
                state     <= IDLE;
                playing   <= 1'b0;
              end else begin
                note_addr <= note_addr + 1'b1;
                fetch_cnt <= 1'b0;
                if (play_btn) begin
                  state     <= PAUSE;
                  ret_state <= FETCH;
                end else begin
                  state <= FETCH;
                end
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
              if (play_btn) begin
                state     <= PAUSE;
                ret_state <= GAP;
              end
            end
          end
          PAUSE: begin
            if (play_btn) begin
              state <= ret_state;
              mute  <= (ret_state != PLAY);
            end
          end
          default: begin
            state   <= IDLE;
            playing <= 1'b0;
            mute    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
